vec_exec_seq: RTL and testbench

- Element sequencer sitting directly upstream of the 8-bit element ALU in the vector processor.
- Accepts one vector instruction, then walks its elements in order:
  - reads operand elements from the vector register file;
  - drives ALU operand and opcode inputs;
  - writes each ALU result back to the destination vector register one cycle later.
- One element per cycle; signals completion with a one-cycle done pulse.

---
 rtl/vec_pkg.sv | 27 ++
 rtl/vec_op_decode.sv | 29 ++
 rtl/vec_exec_seq.sv | 162 ++++++++++++++++
 tb/tb_vec_exec_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector element sequencer and issue logic.
// Opcode map, sequencer state encoding and default geometry.
package vec_pkg;

    localparam int VLEN_DEF = 8;
    localparam int EW_DEF   = 8;
    localparam int RA_DEF   = 3;

    localparam logic [3:0] OP_ADD_VV = 4'b0001;
    localparam logic [3:0] OP_SUB_VV = 4'b0010;
    localparam logic [3:0] OP_XOR_VS = 4'b0101;
    localparam logic [3:0] OP_SHL_VS = 4'b0110;
    localparam logic [3:0] OP_SHR_VS = 4'b0111;
    localparam logic [3:0] OP_ROL_VS = 4'b1000;
    localparam logic [3:0] OP_ROR_VS = 4'b1001;
    localparam logic [3:0] OP_ADD_VS = 4'b1010;
    localparam logic [3:0] OP_SUB_VS = 4'b1011;
    localparam logic [3:0] OP_VFS    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        DRAIN = 2'b10,
        ERR   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/vec_op_decode.sv
// Opcode classifier: legal opcode and whether operand B is the scalar.
module vec_op_decode
    import vec_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_legal,
    output logic       o_scalar_sel
);

    always_comb begin
        o_legal      = 1'b0;
        o_scalar_sel = 1'b0;
        unique case (i_opcode)
            OP_ADD_VV, OP_SUB_VV: begin
                o_legal = 1'b1;
            end
            OP_XOR_VS, OP_SHL_VS, OP_SHR_VS, OP_ROL_VS,
            OP_ROR_VS, OP_ADD_VS, OP_SUB_VS, OP_VFS: begin
                o_legal      = 1'b1;
                o_scalar_sel = 1'b1;
            end
            default: begin
                o_legal      = 1'b0;
                o_scalar_sel = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vec_exec_seq.sv
// Element sequencer: walks one vector instruction element by element,
// feeding the ALU and writing each result back one cycle later.
module vec_exec_seq
    import vec_pkg::*;
#(
    parameter int VLEN = VLEN_DEF,
    parameter int EW   = EW_DEF,
    parameter int RA   = RA_DEF,
    parameter int IW   = $clog2(VLEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_opcode,
    input  logic [RA-1:0] instr_va,
    input  logic [RA-1:0] instr_vb,
    input  logic [RA-1:0] instr_vd,
    input  logic [EW-1:0] instr_scalar,
    output logic [RA-1:0] rf_raddr_a,
    output logic [RA-1:0] rf_raddr_b,
    output logic [IW-1:0] rf_rindex,
    input  logic [EW-1:0] rf_rdata_a,
    input  logic [EW-1:0] rf_rdata_b,
    output logic          rf_we,
    output logic [RA-1:0] rf_waddr,
    output logic [IW-1:0] rf_windex,
    output logic [EW-1:0] rf_wdata,
    output logic [EW-1:0] alu_val_a,
    output logic [EW-1:0] alu_val_b,
    output logic [3:0]    alu_opcode,
    input  logic [EW-1:0] alu_result,
    output logic          done,
    output logic          illegal
);

    seq_state_e    r_state;
    seq_state_e    w_next;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_next;

    logic [3:0]    r_op;
    logic [RA-1:0] r_va;
    logic [RA-1:0] r_vb;
    logic [RA-1:0] r_vd;
    logic [EW-1:0] r_scalar;
    logic          r_scalar_sel;

    logic          r_we;
    logic [RA-1:0] r_waddr;
    logic [IW-1:0] r_windex;
    logic [EW-1:0] r_wdata;

    logic          w_legal;
    logic          w_scalar_sel;
    logic          w_accept;
    logic          w_last;
    logic          w_busy;
    logic          w_exec;

    vec_op_decode u_dec (
        .i_opcode     (instr_opcode),
        .o_legal      (w_legal),
        .o_scalar_sel (w_scalar_sel)
    );

    assign w_accept = instr_valid && (r_state == IDLE);
    assign w_last   = (r_idx == IW'(VLEN - 1));
    assign w_busy   = (r_state != IDLE);
    assign w_exec   = (r_state == EXEC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_idx_next  = r_idx;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        unique case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                w_idx_next  = '0;
                if (instr_valid) begin
                    w_next = w_legal ? EXEC : ERR;
                end
            end
            EXEC: begin
                // Power-of-two VLEN lets the index wrap to 0 on its own.
                w_idx_next = r_idx + IW'(1);
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op         <= '0;
            r_va         <= '0;
            r_vb         <= '0;
            r_vd         <= '0;
            r_scalar     <= '0;
            r_scalar_sel <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_windex     <= '0;
            r_wdata      <= '0;
        end else begin
            if (w_accept) begin
                r_op         <= instr_opcode;
                r_va         <= instr_va;
                r_vb         <= instr_vb;
                r_vd         <= instr_vd;
                r_scalar     <= instr_scalar;
                r_scalar_sel <= w_scalar_sel;
            end
            r_we <= w_exec;
            if (w_exec) begin
                r_waddr  <= r_vd;
                r_windex <= r_idx;
                r_wdata  <= alu_result;
            end
        end
    end

    assign rf_raddr_a = r_va;
    assign rf_raddr_b = r_vb;
    assign rf_rindex  = r_idx;

    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_windex  = r_windex;
    assign rf_wdata   = r_wdata;

    assign alu_opcode = w_busy ? r_op : 4'b0000;
    assign alu_val_a  = w_busy ? rf_rdata_a : '0;
    assign alu_val_b  = !w_busy     ? '0 :
                        r_scalar_sel ? r_scalar : rf_rdata_b;

endmodule

// File: tb/tb_vec_exec_seq.sv
// Bench for vec_exec_seq: register file and ALU models around the DUT,
// table vectors, corner sequences and random instructions.
module tb_vec_exec_seq;

    localparam int VLEN = 8;
    localparam int EW   = 8;
    localparam int RA   = 3;
    localparam int IW   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_opcode;
    logic [RA-1:0] instr_va;
    logic [RA-1:0] instr_vb;
    logic [RA-1:0] instr_vd;
    logic [EW-1:0] instr_scalar;
    logic [RA-1:0] rf_raddr_a;
    logic [RA-1:0] rf_raddr_b;
    logic [IW-1:0] rf_rindex;
    logic [EW-1:0] rf_rdata_a;
    logic [EW-1:0] rf_rdata_b;
    logic          rf_we;
    logic [RA-1:0] rf_waddr;
    logic [IW-1:0] rf_windex;
    logic [EW-1:0] rf_wdata;
    logic [EW-1:0] alu_val_a;
    logic [EW-1:0] alu_val_b;
    logic [3:0]    alu_opcode;
    logic [EW-1:0] alu_result;
    logic          done;
    logic          illegal;

    vec_exec_seq #(
        .VLEN(VLEN), .EW(EW), .RA(RA), .IW(IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_va     (instr_va),
        .instr_vb     (instr_vb),
        .instr_vd     (instr_vd),
        .instr_scalar (instr_scalar),
        .rf_raddr_a   (rf_raddr_a),
        .rf_raddr_b   (rf_raddr_b),
        .rf_rindex    (rf_rindex),
        .rf_rdata_a   (rf_rdata_a),
        .rf_rdata_b   (rf_rdata_b),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_windex    (rf_windex),
        .rf_wdata     (rf_wdata),
        .alu_val_a    (alu_val_a),
        .alu_val_b    (alu_val_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .done         (done),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] i;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  va;
        logic [2:0]  vb;
        logic [2:0]  vd;
        logic [7:0]  sc;
        logic        ill;
        logic [63:0] wd;
    } vec_t;

    logic [7:0]  rf     [8][8];
    logic [7:0]  ref_rf [8][8];
    wr_t         wlog [$];
    wr_t         exp_q [$];
    logic [7:0]  exp_a [VLEN];
    logic [7:0]  exp_b [VLEN];
    logic        exp_ill;
    logic        seen_ill;
    int          base;
    int          errors = 0;
    int          checks = 0;

    logic        pl_en = 1'b0;
    logic [2:0]  pl_row = '0;
    logic [63:0] pl_vals = '0;

    vec_t        tbl [6];
    logic [3:0]  legal_ops [10];
    logic [3:0]  bad_ops [6];
    logic [3:0]  t_op;
    logic [2:0]  t_va, t_vb, t_vd;
    logic [7:0]  t_sc;
    logic [7:0]  save_row [8];

    function automatic logic [7:0] alu_fn(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [15:0] t;
        logic [2:0]  s;
        s = b[2:0];
        t = {a, a};
        case (op)
            4'h1, 4'hA: return a + b;
            4'h2, 4'hB: return a - b;
            4'h5: return a ^ b;
            4'h6: return a << s;
            4'h7: return a >> s;
            4'h8: begin t = t << s; return t[15:8]; end
            4'h9: begin t = t >> s; return t[7:0]; end
            4'hF: return b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_opcode, alu_val_a, alu_val_b);

    assign rf_rdata_a = rf[rf_raddr_a][rf_rindex];
    assign rf_rdata_b = rf[rf_raddr_b][rf_rindex];

    always @(posedge clk) begin
        if (pl_en) begin
            for (int k = 0; k < VLEN; k++) rf[pl_row][k] <= pl_vals[8*k +: 8];
        end else if (rf_we) begin
            rf[rf_waddr][rf_windex] <= rf_wdata;
            wlog.push_back(wr_t'{rf_waddr, rf_windex, rf_wdata});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rf(input string nm);
        int bad;
        bad = 0;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < VLEN; k++)
                if (rf[r][k] !== ref_rf[r][k]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic load_row(input int r, input logic [63:0] v);
        pl_row  = 3'(r);
        pl_vals = v;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        for (int k = 0; k < VLEN; k++) ref_rf[r][k] = v[8*k +: 8];
    endtask

    // Reference: elements processed in order, each result stored immediately.
    function automatic void ref_exec(input logic [3:0] op, input logic [2:0] va,
                                     input logic [2:0] vb, input logic [2:0] vd,
                                     input logic [7:0] sc);
        logic [7:0] a, b, r;
        exp_q.delete();
        exp_ill = !(op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hA, 4'hB, 4'hF});
        if (exp_ill) return;
        for (int k = 0; k < VLEN; k++) begin
            a = ref_rf[va][k];
            b = (op inside {4'h1, 4'h2}) ? ref_rf[vb][k] : sc;
            r = alu_fn(op, a, b);
            exp_a[k] = a;
            exp_b[k] = b;
            ref_rf[vd][k] = r;
            exp_q.push_back(wr_t'{vd, 3'(k), r});
        end
    endfunction

    task automatic issue(input logic [3:0] op, input logic [2:0] va,
                         input logic [2:0] vb, input logic [2:0] vd,
                         input logic [7:0] sc);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", instr_ready, 1);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_va     = va;
        instr_vb     = vb;
        instr_vd     = vd;
        instr_scalar = sc;
        base = wlog.size();
        @(posedge clk);
        #1;
        instr_valid  = 1'b0;
        instr_opcode = 4'($urandom);
        instr_va     = 3'($urandom);
        instr_vb     = 3'($urandom);
        instr_vd     = 3'($urandom);
        instr_scalar = 8'($urandom);
    endtask

    task automatic run_check(input logic [3:0] op);
        int c;
        bit got;
        c = 0;
        got = 1'b0;
        while (!got && c < VLEN + 4) begin
            @(negedge clk);
            c++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk("busy_ready", instr_ready, 0);
                chk("alu_op", alu_opcode, op);
                chk("we_exec", rf_we, c >= 2);
                if (c <= VLEN) begin
                    chk("rindex", rf_rindex, c - 1);
                    chk("val_a", alu_val_a, exp_a[c-1]);
                    chk("val_b", alu_val_b, exp_b[c-1]);
                end
            end
        end
        seen_ill = illegal;
        chk("done_seen", got, 1);
        chk("done_cyc", c, exp_ill ? 1 : VLEN + 1);
        chk("illegal", illegal, exp_ill);
        chk("we_done", rf_we, !exp_ill);
        chk("ready_done", instr_ready, 0);
        @(negedge clk);
        chk("ready_back", instr_ready, 1);
        chk("done_pulse", done, 0);
        chk("ill_pulse", illegal, 0);
        chk("we_idle", rf_we, 0);
        chk("n_wr", wlog.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < wlog.size()) chk("wr", wlog[base+i], exp_q[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, t0, t1, n_acc, busy, bad;

        legal_ops = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
        bad_ops   = '{4'h0, 4'h3, 4'h4, 4'hC, 4'hD, 4'hE};
        tbl[0] = '{4'h1, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 64'h11100F0E0D0C0B0A};
        tbl[1] = '{4'hB, 3'd1, 3'd2, 3'd5, 8'h05, 1'b0, 64'h020100FFFEFDFCFB};
        tbl[2] = '{4'h3, 3'd1, 3'd2, 3'd3, 8'h00, 1'b1, 64'h0};
        tbl[3] = '{4'hA, 3'd4, 3'd0, 3'd4, 8'h01, 1'b0, 64'h0807060504030201};
        tbl[4] = '{4'h5, 3'd1, 3'd0, 3'd6, 8'hFF, 1'b0, 64'hF8F9FAFBFCFDFEFF};
        tbl[5] = '{4'h2, 3'd2, 3'd1, 3'd7, 8'h00, 1'b0, 64'h030405060708090A};

        reset = 1'b1;
        instr_valid = 1'b0;
        instr_opcode = '0;
        instr_va = '0;
        instr_vb = '0;
        instr_vd = '0;
        instr_scalar = '0;
        repeat (2) @(negedge clk);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_windex", rf_windex, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_rindex", rf_rindex, 0);
        chk("rst_aluop", alu_opcode, 0);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) load_row(r, {$urandom, $urandom});
        load_row(1, 64'h0706050403020100);
        load_row(2, 64'h0A0A0A0A0A0A0A0A);
        load_row(4, 64'h0706050403020100);

        for (int t = 0; t < 6; t++) begin
            ref_exec(tbl[t].op, tbl[t].va, tbl[t].vb, tbl[t].vd, tbl[t].sc);
            issue(tbl[t].op, tbl[t].va, tbl[t].vb, tbl[t].vd, tbl[t].sc);
            run_check(tbl[t].op);
            chk("tbl_ill", seen_ill, tbl[t].ill);
            if (!tbl[t].ill)
                for (int k = 0; k < VLEN; k++)
                    if (base + k < wlog.size())
                        chk("tbl_wd", wlog[base+k].d, tbl[t].wd[8*k +: 8]);
            if (t == 1) chk("idle_val_b", alu_val_b, 0);
            chk_rf("tbl_rf");
        end
        chk("idle_aluop", alu_opcode, 0);
        chk("idle_val_a", alu_val_a, 0);

        // Back-to-back with instr_valid held high.
        ref_exec(4'h1, 3'd1, 3'd2, 3'd0, 8'h00);
        ref_exec(4'h8, 3'd3, 3'd0, 3'd1, 8'h03);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_opcode = 4'h1; instr_va = 3'd1; instr_vb = 3'd2;
        instr_vd = 3'd0; instr_scalar = 8'h00;
        n_acc = 0; t0 = 0; t1 = 0; busy = 0; n = 0;
        while (n_acc < 2 && n < 3 * (VLEN + 2)) begin
            if (instr_ready) begin
                if (n_acc == 0) t0 = n;
                else t1 = n;
                n_acc++;
            end else if (n_acc == 1) begin
                busy++;
            end
            @(posedge clk);
            #1;
            if (n_acc == 1) begin
                instr_opcode = 4'h8; instr_va = 3'd3; instr_vb = 3'd0;
                instr_vd = 3'd1; instr_scalar = 8'h03;
            end
            if (n_acc == 2) instr_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_spacing", t1 - t0, VLEN + 2);
        chk("b2b_busy", busy, VLEN + 1);
        n = 0;
        while (!done && n < VLEN + 6) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done", done, 1);
        @(negedge clk);
        chk_rf("b2b_rf");

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) < 8) t_op = legal_ops[$urandom_range(0, 9)];
            else t_op = bad_ops[$urandom_range(0, 5)];
            t_va = 3'($urandom);
            t_vb = 3'($urandom);
            t_vd = 3'($urandom);
            t_sc = 8'($urandom);
            ref_exec(t_op, t_va, t_vb, t_vd, t_sc);
            issue(t_op, t_va, t_vb, t_vd, t_sc);
            run_check(t_op);
            chk_rf("rnd_rf");
        end

        // Reset while the element-3 write is being presented.
        for (int k = 0; k < VLEN; k++) save_row[k] = ref_rf[6][k];
        ref_exec(4'hA, 3'd5, 3'd0, 3'd6, 8'h20);
        for (int k = 3; k < VLEN; k++) ref_rf[6][k] = save_row[k];
        issue(4'hA, 3'd5, 3'd0, 3'd6, 8'h20);
        n = 0;
        while (!(rf_we && rf_windex == 3'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", rf_we && rf_windex == 3'd3, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we", rf_we, 0);
        chk("arst_ready", instr_ready, 1);
        chk("arst_done", done, 0);
        chk("arst_wdata", rf_wdata, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < VLEN + 4; i++) begin
            @(negedge clk);
            if (done || rf_we || !instr_ready) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk_rf("rst_rf");

        ref_exec(4'h6, 3'd6, 3'd0, 3'd2, 8'h02);
        issue(4'h6, 3'd6, 3'd0, 3'd2, 8'h02);
        run_check(4'h6);
        chk_rf("restart_rf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
